// File: rtl/entrada_switches_handshake.sv
// Confirm-button debouncer plus switch-capture handshake that feeds the input instruction path.
// A released->pressed->released gesture while req_entrada is high yields one dado_valido pulse.

module entrada_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic CLK,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press_evt
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt;

    // Released (1) is the idle level for the synchronizer and the filtered output.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            sync_q    <= 2'b11;
            level     <= 1'b1;
            cnt       <= '0;
            press_evt <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], raw};
            press_evt <= 1'b0;
            if (sync_q[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_TERM) begin
                level     <= sync_q[1];
                cnt       <= '0;
                press_evt <= ~sync_q[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module entrada_switches_handshake #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SW_W            = 16,
    parameter int DATA_W          = 32,
    parameter int SIGN_EXT        = 0
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [SW_W-1:0]   Switches,
    input  logic              botao_confirma,
    input  logic              req_entrada,
    output logic [DATA_W-1:0] dado_entrada,
    output logic              dado_valido,
    output logic              aguardando
);
    typedef enum logic [2:0] {
        OCIOSO,
        ESPERA_PRESS,
        ESPERA_SOLTA,
        ENTREGA,
        ESPERA_BAIXA
    } estado_t;

    estado_t           estado;
    logic              btn_solto;
    logic              press_evt;
    logic [SW_W-1:0]   captura;
    logic [DATA_W-1:0] captura_ext;

    entrada_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .CLK      (CLK),
        .reset    (reset),
        .raw      (botao_confirma),
        .level    (btn_solto),
        .press_evt(press_evt)
    );

    always_comb begin
        captura_ext             = '0;
        captura_ext[SW_W-1:0]   = captura;
        for (int i = SW_W; i < DATA_W; i++) begin
            captura_ext[i] = (SIGN_EXT != 0) ? captura[SW_W-1] : 1'b0;
        end
    end

    // aguardando is updated alongside every state change so it stays a clean registered level.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            estado       <= OCIOSO;
            captura      <= '0;
            dado_entrada <= '0;
            dado_valido  <= 1'b0;
            aguardando   <= 1'b0;
        end else begin
            dado_valido <= 1'b0;
            case (estado)
                OCIOSO: begin
                    // A press already held when the request arrives must be released first.
                    if (req_entrada && btn_solto) begin
                        estado     <= ESPERA_PRESS;
                        aguardando <= 1'b1;
                    end
                end
                ESPERA_PRESS: begin
                    if (!req_entrada) begin
                        estado     <= OCIOSO;
                        aguardando <= 1'b0;
                    end else if (press_evt) begin
                        captura <= Switches;
                        estado  <= ESPERA_SOLTA;
                    end
                end
                ESPERA_SOLTA: begin
                    if (!req_entrada) begin
                        estado     <= OCIOSO;
                        aguardando <= 1'b0;
                    end else if (btn_solto) begin
                        estado     <= ENTREGA;
                        aguardando <= 1'b0;
                    end
                end
                ENTREGA: begin
                    dado_entrada <= captura_ext;
                    dado_valido  <= 1'b1;
                    estado       <= ESPERA_BAIXA;
                end
                ESPERA_BAIXA: begin
                    if (!req_entrada) estado <= OCIOSO;
                end
                default: begin
                    estado     <= OCIOSO;
                    aguardando <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_entrada_switches_handshake.sv
// Bench for entrada_switches_handshake: zero- and sign-extending instances share stimulus;
// deliveries are checked against a queue of expected words.

module tb_entrada_switches_handshake;
    logic        CLK = 1'b0;
    logic        reset;
    logic [15:0] sw;
    logic        botao;
    logic        req;
    logic [31:0] d0, d1;
    logic        v0, v1, a0, a1;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];

    typedef struct {
        logic [15:0] sw;
        int          press_len;
        bit          deliver;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } vec_t;

    vec_t tbl[6];

    always #5 CLK = ~CLK;

    entrada_switches_handshake #(
        .DEBOUNCE_CYCLES(4), .SW_W(16), .DATA_W(32), .SIGN_EXT(0)
    ) dut_zext (
        .CLK(CLK), .reset(reset), .Switches(sw), .botao_confirma(botao),
        .req_entrada(req), .dado_entrada(d0), .dado_valido(v0), .aguardando(a0)
    );

    entrada_switches_handshake #(
        .DEBOUNCE_CYCLES(4), .SW_W(16), .DATA_W(32), .SIGN_EXT(1)
    ) dut_sext (
        .CLK(CLK), .reset(reset), .Switches(sw), .botao_confirma(botao),
        .req_entrada(req), .dado_entrada(d1), .dado_valido(v1), .aguardando(a1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock; any valid pulse is matched against the head of its queue.
    task automatic tick();
        @(posedge CLK);
        #1;
        if (v0) begin
            if (q0.size() == 0) chk("spurious_valid_zext", {31'b0, v0}, 32'd0);
            else chk("data_zext", d0, q0.pop_front());
        end
        if (v1) begin
            if (q1.size() == 0) chk("spurious_valid_sext", {31'b0, v1}, 32'd0);
            else chk("data_sext", d1, q1.pop_front());
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic wait_agu(input logic e, input int max);
        int k = 0;
        while ((a0 !== e || a1 !== e) && k < max) begin
            tick();
            k++;
        end
        chk("aguardando_zext", {31'b0, a0}, {31'b0, e});
        chk("aguardando_sext", {31'b0, a1}, {31'b0, e});
    endtask

    task automatic press(input int len);
        botao = 1'b0;
        ticks(len);
        botao = 1'b1;
    endtask

    initial begin
        tbl[0] = '{16'h1234, 3,  1'b0, 32'h0, 32'h0};
        tbl[1] = '{16'h1234, 3,  1'b0, 32'h0, 32'h0};
        tbl[2] = '{16'h8001, 10, 1'b1, 32'h0000_8001, 32'hFFFF_8001};
        tbl[3] = '{16'hFFFF, 4,  1'b1, 32'h0000_FFFF, 32'hFFFF_FFFF};
        tbl[4] = '{16'h0000, 2,  1'b0, 32'h0, 32'h0};
        tbl[5] = '{16'h7FFF, 10, 1'b1, 32'h0000_7FFF, 32'h0000_7FFF};

        reset = 1'b0; req = 1'b0; botao = 1'b1; sw = '0;
        ticks(2);
        chk("reset_data", d0, 32'h0);
        chk("reset_valid", {31'b0, v0}, 32'h0);
        chk("reset_agu", {31'b0, a0}, 32'h0);
        reset = 1'b1;
        ticks(2);

        // Normal delivery with exact latency from physical release.
        sw  = 16'h00A5;
        req = 1'b1;
        wait_agu(1'b1, 4);
        q0.push_back(32'h0000_00A5);
        q1.push_back(32'h0000_00A5);
        press(10);
        ticks(6);
        chk("agu_until_release", {31'b0, a0}, 32'h1);
        tick();
        chk("agu_drop", {31'b0, a0}, 32'h0);
        chk("valid_early", {31'b0, v0}, 32'h0);
        tick();
        chk("valid_latency", {31'b0, v0}, 32'h1);
        tick();
        chk("valid_width", {31'b0, v0}, 32'h0);
        chk("data_held", d0, 32'h0000_00A5);
        req = 1'b0;
        ticks(3);

        // Table: glitches, boundary-length press, extension cases.
        for (int r = 0; r < 6; r++) begin
            req = 1'b1;
            wait_agu(1'b1, 12);
            sw = tbl[r].sw;
            if (tbl[r].deliver) begin
                q0.push_back(tbl[r].exp0);
                q1.push_back(tbl[r].exp1);
            end
            press(tbl[r].press_len);
            ticks(12);
            if (tbl[r].deliver) begin
                chk("tbl_agu_done", {31'b0, a0}, 32'h0);
                chk("tbl_pending", q0.size() + q1.size(), 32'd0);
                req = 1'b0;
                ticks(3);
            end else begin
                chk("tbl_agu_still_waiting", {31'b0, a0}, 32'h1);
            end
        end
        req = 1'b0;
        ticks(3);

        // Button held before the request: no progress until released, then one delivery only.
        botao = 1'b0;
        ticks(10);
        req = 1'b1;
        ticks(5);
        chk("held_no_wait", {31'b0, a0}, 32'h0);
        botao = 1'b1;
        wait_agu(1'b1, 12);
        sw = 16'h0042;
        q0.push_back(32'h0000_0042);
        q1.push_back(32'h0000_0042);
        press(10);
        ticks(12);
        chk("held_pending", q0.size() + q1.size(), 32'd0);
        press(10);
        ticks(12);
        chk("second_press_agu", {31'b0, a0}, 32'h0);
        req = 1'b0;
        ticks(3);

        // Abort while waiting for release.
        req = 1'b1;
        wait_agu(1'b1, 12);
        sw = 16'h5555;
        botao = 1'b0;
        ticks(10);
        req = 1'b0;
        ticks(2);
        chk("abort_agu", {31'b0, a0}, 32'h0);
        botao = 1'b1;
        ticks(12);
        chk("abort_keep_zext", d0, 32'h0000_0042);
        chk("abort_keep_sext", d1, 32'h0000_0042);

        // req falls in the very cycle press_evt is high.
        req = 1'b1;
        wait_agu(1'b1, 12);
        sw = 16'hDEAD;
        botao = 1'b0;
        ticks(6);
        chk("pre_evt_agu", {31'b0, a0}, 32'h1);
        req = 1'b0;
        tick();
        chk("abort_vs_press", {31'b0, a0}, 32'h0);
        botao = 1'b1;
        ticks(12);
        chk("abort_evt_keep", d0, 32'h0000_0042);

        // Asynchronous reset in the middle of ESPERA_SOLTA.
        req = 1'b1;
        wait_agu(1'b1, 12);
        sw = 16'h1111;
        press(10);
        ticks(2);
        chk("pre_reset_agu", {31'b0, a0}, 32'h1);
        #2 reset = 1'b0;
        #1;
        chk("async_reset_data", d0, 32'h0);
        chk("async_reset_agu", {31'b0, a0}, 32'h0);
        chk("async_reset_sext", d1, 32'h0);
        ticks(2);
        reset = 1'b1;
        wait_agu(1'b1, 4);
        sw = 16'h9000;
        q0.push_back(32'h0000_9000);
        q1.push_back(32'hFFFF_9000);
        press(10);
        ticks(12);
        req = 1'b0;
        ticks(3);

        chk("final_pending", q0.size() + q1.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
